// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder -- bit-serial, LSB-first adder with valid/ready on both sides.
//
// Operands are captured on the input handshake. One bit per clock then goes
// through a full-adder slice made of two half_adder cells plus an OR. The
// carry between bits is registered. After WIDTH shift cycles the WIDTH-bit sum
// and the carry-out are held until the output handshake completes.
//
// Optional feature (macro SERIAL_ADDER_SUB_EN):
//   Adds input 'sub', which is sampled at accept. When sub=1 the block loads
//   ~b and starts with carry-in 1, so the result is a-b mod 2^WIDTH. In that
//   case carry=1 means no borrow. When the macro is undefined there is no
//   'sub' port and the block only adds.
//
// Parameters:
//   WIDTH      operand/sum width, 1..32 (default 8)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair a/b presented
//   in_ready   block can accept operands (high in IDLE)
//   a, b       operands, WIDTH bits
//   sub        (SERIAL_ADDER_SUB_EN only) subtract instead of add
//   out_valid  sum/carry valid (high in HOLD)
//   out_ready  consumer accepts result
//   sum        result, WIDTH bits; holds the last delivered value
//   carry      carry-out of MSB
//   busy       high while shifting
// -----------------------------------------------------------------------------

// Existing single-bit half adder cell, used twice per bit.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             c_reg;
  logic [CW-1:0]    cnt;

  // Per-bit full adder: two half adders, and the carries are ORed.
  logic p_bit;
  logic g_bit;
  logic s_bit;
  logic cp_bit;
  logic c_next;

  half_adder u_ha_lo (
    .x (a_sr[0]),
    .y (b_sr[0]),
    .s (p_bit),
    .c (g_bit)
  );

  half_adder u_ha_hi (
    .x (p_bit),
    .y (c_reg),
    .s (s_bit),
    .c (cp_bit)
  );

  assign c_next = g_bit | cp_bit;

  // The new sum bit enters at the MSB. After WIDTH shifts the LSB-first
  // stream ends up in the correct bit positions.
  logic [WIDTH-1:0] sum_shift;
  always_comb begin
    sum_shift            = sum_sr >> 1;
    sum_shift[WIDTH-1]   = s_bit;
  end

  // Values loaded at accept. For subtraction this is the two's-complement
  // trick: invert b and inject a carry-in of 1.
  logic [WIDTH-1:0] b_load;
  logic             c_init;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_init = sub;
`else
  assign b_load = b;
  assign c_init = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      c_reg     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry     <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr      <= a;
            b_sr      <= b_load;
            c_reg     <= c_init;
            cnt       <= '0;
            state     <= SHIFT;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end

        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_shift;
          c_reg  <= c_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            // The final bit is produced here. It goes straight to the output
            // registers so that sum and carry appear together with out_valid.
            sum       <= sum_shift;
            carry     <= c_next;
            state     <= HOLD;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end

        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder -- self-checking bench for serial_adder (WIDTH=8).
//
// A cycle-level reference runs at every falling edge. It computes the result
// with plain integer arithmetic when an operand pair is accepted. It tracks
// timing as the number of cycles since accept, and compares every DUT output.
// Directed transactions also check hand-computed literal results.
// Define SERIAL_ADDER_SUB_EN to enable the subtract vectors.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             busy;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub_i;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. since_acc = -1 means no transaction is in flight.
  // since_acc = 1..WIDTH means shifting. since_acc = WIDTH+1 means the result
  // is on offer.
  // ---------------------------------------------------------------------------
  int               since_acc = -1;
  logic [WIDTH:0]   pending   = '0;
  logic [WIDTH-1:0] dlv_sum   = '0;
  logic             dlv_carry = 1'b0;

  always @(negedge clk) begin
    logic ready_e, busy_e, valid_e;
    logic sub_e;
    if (!rst_n) begin
      since_acc = -1;
      dlv_sum   = '0;
      dlv_carry = 1'b0;
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy",      busy,      0);
      chk("rst_sum",       sum,       0);
      chk("rst_carry",     carry,     0);
    end else begin
      ready_e = (since_acc < 0);
      busy_e  = (since_acc >= 1) && (since_acc <= WIDTH);
      valid_e = (since_acc == WIDTH + 1);
      chk("m_in_ready",  in_ready,  ready_e);
      chk("m_busy",      busy,      busy_e);
      chk("m_out_valid", out_valid, valid_e);
      chk("m_sum",       sum,       dlv_sum);
      chk("m_carry",     carry,     dlv_carry);
      // Advance the model to what the next rising edge will do.
      if (ready_e) begin
        if (in_valid) begin
          sub_e = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
          sub_e = sub_i;
`endif
          if (sub_e)
            pending = {1'b0, a} + {1'b0, ~b} + 1;
          else
            pending = {1'b0, a} + {1'b0, b};
          since_acc = 1;
        end
      end else if (busy_e) begin
        since_acc++;
        if (since_acc == WIDTH + 1) begin
          dlv_sum   = pending[WIDTH-1:0];
          dlv_carry = pending[WIDTH];
        end
      end else if (valid_e && out_ready) begin
        since_acc = -1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed transaction: accept, count busy cycles, check the literal result,
  // optionally stall in HOLD with junk operands offered, then release.
  // Called at posedge+1 with the DUT idle.
  // ---------------------------------------------------------------------------
  task automatic run_txn(input logic [7:0] ta, input logic [7:0] tb_v, input logic tsub,
                         input int hold_n, input logic [7:0] es, input logic ec,
                         input string nm);
    int n;
    int guard;
    chk({nm, "_in_ready"}, in_ready, 1);
    a = ta;
    b = tb_v;
`ifdef SERIAL_ADDER_SUB_EN
    sub_i = tsub;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    guard = 0;
    while (!out_valid && guard < 100) begin
      if (busy) n++;
      guard++;
      @(posedge clk); #1;
    end
    chk({nm, "_no_timeout"}, (guard < 100), 1);
    chk({nm, "_busy_cycles"}, n, 8);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_carry"}, carry, ec);
    if (hold_n > 0) begin
      in_valid = 1'b1;
      a = 8'h11;
      b = 8'h22;
    end
    for (int i = 0; i < hold_n; i++) begin
      @(posedge clk); #1;
      chk({nm, "_hold_valid"}, out_valid, 1);
      chk({nm, "_hold_sum"},   sum,       es);
      chk({nm, "_hold_carry"}, carry,     ec);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_ready_after"}, in_ready, 1);
    chk({nm, "_sum_kept"}, sum, es);
    @(posedge clk); #1;
    chk({nm, "_not_accepted"}, busy, 0);
    $display("txn %s: a=0x%02h b=0x%02h sub=%0d -> sum=0x%02h carry=%0d", nm, ta, tb_v, tsub, sum, carry);
  endtask

  initial begin
    int c1, c2, idle_n, guard;
    logic [7:0] r1_sum;
    logic       r1_carry;
    logic       r1_seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub_i     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_sum", sum, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 1);

    run_txn(8'h00, 8'h00, 1'b0, 0, 8'h00, 1'b0, "zero");
    run_txn(8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, "ff_plus_1");
    run_txn(8'hFF, 8'hFF, 1'b0, 0, 8'hFE, 1'b1, "ff_plus_ff");
    run_txn(8'hA5, 8'h5A, 1'b0, 5, 8'hFF, 1'b0, "a5_5a_stall");

    // Back-to-back with out_ready tied high.
    out_ready = 1'b1;
    a = 8'h0F;
    b = 8'h01;
    in_valid = 1'b1;
    chk("b2b_ready0", in_ready, 1);
    @(posedge clk); #1;
    c1 = cyc;
    a = 8'h80;
    b = 8'h80;
    idle_n = 0;
    guard = 0;
    r1_seen = 1'b0;
    r1_sum = '0;
    r1_carry = 1'b0;
    while (!in_ready && guard < 100) begin
      if (out_valid) begin
        r1_seen  = 1'b1;
        r1_sum   = sum;
        r1_carry = carry;
      end
      guard++;
      @(posedge clk); #1;
    end
    chk("b2b_no_timeout1", (guard < 100), 1);
    chk("b2b_r1_seen", r1_seen, 1);
    chk("b2b_r1_sum", r1_sum, 8'h10);
    chk("b2b_r1_carry", r1_carry, 0);
    while (in_ready && idle_n < 10) begin
      idle_n++;
      @(posedge clk); #1;
    end
    c2 = cyc;
    chk("b2b_idle_cycles", idle_n, 1);
    chk("b2b_period", c2 - c1, WIDTH + 2);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin
      guard++;
      @(posedge clk); #1;
    end
    chk("b2b_no_timeout2", (guard < 100), 1);
    chk("b2b_r2_sum", sum, 8'h00);
    chk("b2b_r2_carry", carry, 1);
    $display("txn b2b: 0x0F+0x01 -> 0x%02h/%0d, 0x80+0x80 -> 0x%02h/%0d", r1_sum, r1_carry, sum, carry);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Abort on the third SHIFT cycle.
    a = 8'h33;
    b = 8'h44;
    in_valid = 1'b1;
    @(posedge clk); #1;          // accept: now in SHIFT cycle 1
    in_valid = 1'b0;
    @(posedge clk); #1;          // SHIFT cycle 2
    @(posedge clk); #1;          // SHIFT cycle 3
    chk("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_sum", sum, 0);
    chk("abort_carry", carry, 0);
    chk("abort_busy", busy, 0);
    $display("txn abort: reset mid-shift -> in_ready=%0d out_valid=%0d sum=0x%02h", in_ready, out_valid, sum);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(8'h33, 8'h44, 1'b0, 0, 8'h77, 1'b0, "after_abort");

`ifdef SERIAL_ADDER_SUB_EN
    run_txn(8'h05, 8'h03, 1'b1, 0, 8'h02, 1'b1, "sub_5_3");
    run_txn(8'h03, 8'h05, 1'b1, 0, 8'hFE, 1'b0, "sub_3_5");
    run_txn(8'h05, 8'h03, 1'b0, 0, 8'h08, 1'b0, "add_5_3");
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
